fifo_uart_tx: RTL

Read-side consumer for the team's byte FIFO. Pops one word at a time through the FIFO's `rd`/`empty`/`rdata` port and shifts it out as an asynchronous serial frame: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit. It sits between the FIFO and the board TX pin, and is the transmit end of the path whose receive side fills the FIFO.

---
 rtl/fifo_uart_tx_pkg.sv | 15 +
 rtl/fifo_uart_tx_if.sv | 14 +
 rtl/fifo_uart_tx_bit_timer.sv | 20 ++
 rtl/fifo_uart_tx.sv | 85 ++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART transmit definitions: FSM state encoding and the idle line level.
package uart_defs;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_POP   = 3'd1;
  localparam state_t ST_LATCH = 3'd2;
  localparam state_t ST_START = 3'd3;
  localparam state_t ST_DATA  = 3'd4;
  localparam state_t ST_STOP  = 3'd5;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port, frame gating and serial line bundle between the FIFO side and the transmitter.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  enable;
  logic                  empty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd;
  logic                  txd;
  logic                  busy;

  modport master (input enable, input empty, input rdata, output rd, output txd, output busy);
  modport slave  (output enable, output empty, output rdata, input rd, input txd, input busy);
endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// Baud counter: tick marks the last clock of each serial bit period; clear holds it at zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = !clear && (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst || clear || tick) cnt <= '0;
    else                       cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one word from the FIFO per frame and shifts it out: start bit, data LSB first, stop bit.
module fifo_uart_tx
  import uart_defs::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  fifo_uart_tx_if.master    bus
);
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

  state_t                state;
  state_t                next_state;
  logic                  rd_q;
  logic [DATA_WIDTH-1:0] shift;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  tick;
  logic                  timer_clear;
  logic                  start_ok;
  logic                  txd_c;
  logic                  busy_c;

  assign start_ok    = bus.enable && !bus.empty;
  assign timer_clear = !(state == ST_START || state == ST_DATA || state == ST_STOP);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .tick  (tick)
  );

  // rd is registered from next_state so it is high exactly while in POP
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      rd_q  <= 1'b0;
    end else begin
      state <= next_state;
      rd_q  <= (next_state == ST_POP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (state == ST_LATCH) begin
      shift   <= bus.rdata;
      bit_cnt <= '0;
    end else if (state == ST_DATA && tick) begin
      shift   <= shift >> 1;
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start_ok) next_state = ST_POP;
      ST_POP:   next_state = ST_LATCH;
      ST_LATCH: next_state = ST_START;
      ST_START: if (tick) next_state = ST_DATA;
      ST_DATA:  if (tick && bit_cnt == BIT_W'(DATA_WIDTH - 1)) next_state = ST_STOP;
      ST_STOP:  if (tick) next_state = start_ok ? ST_POP : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    txd_c  = LINE_IDLE;
    busy_c = (state != ST_IDLE);
    case (state)
      ST_START: txd_c = ~LINE_IDLE;
      ST_DATA:  txd_c = shift[0];
      default:  txd_c = LINE_IDLE;
    endcase
  end

  assign bus.rd   = rd_q;
  assign bus.txd  = txd_c;
  assign bus.busy = busy_c;
endmodule
